uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first. It is the receive-side counterpart of the UART transmit peripheral and uses the same `CLK_FREQ`/`BAUD` parameterisation. It sits between the board `rx` pin and the core's byte consumer. Each received byte is presented through a one-entry holding register with a valid/ready handshake, plus framing-error and overrun status.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync2.sv | 21 ++
 rtl/uart_rx.sv | 157 +++++++++++++++
 tb/tb_uart_rx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-period divider
// that both the transmit and receive sides derive from CLK_FREQ/BAUD.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } uart_rx_state_t;

  function automatic int uart_div(input int clk_mhz, input int baud);
    return int'((longint'(clk_mhz) * 64'd1_000_000) / longint'(baud));
  endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable
// reset level so idle-high lines do not see a false edge out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ff_q <= {2{RST_VAL}};
    else         ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a one-entry holding register,
// single-cycle framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 27,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] dbg_state
);

  localparam int DIV  = uart_div(CLK_FREQ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  if (DIV < 4) begin : g_bad_div
    $error("uart_rx: bit period DIV=%0d is below the minimum of 4", DIV);
  end

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_START     = START;
  localparam logic [2:0] S_DATA      = DATA;
  localparam logic [2:0] S_STOP      = STOP;
  localparam logic [2:0] S_WAIT_IDLE = WAIT_IDLE;

  logic          rxs;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          good_stop, bad_stop, hs;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk),
    .rst_ni(rst),
    .d_i   (rx),
    .q_o   (rxs)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        // Mid-start-bit recheck rejects line glitches shorter than half a bit.
        if (cnt_q == CNT_HALF) begin
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            cnt_d     = '0;
            bit_idx_d = 3'd0;
            state_d   = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          shreg_d   = {rxs, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (rxs) begin
            good_stop = 1'b1;
            state_d   = S_IDLE;
          end else begin
            bad_stop  = 1'b1;
            state_d   = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: a transfer happens only when data_valid & data_ready are
  // both high on a rising edge; data_out is stable while data_valid is high,
  // and a byte arriving while full is dropped unless that same edge transfers.
  always_comb begin
    hs      = valid_q & data_ready;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = bad_stop;
    ovr_d   = ovr_q;
    if (good_stop) begin
      if (!valid_q || hs) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        if (hs) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (hs) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at DIV=10/HALF=5: directed scenarios plus random frames,
// delivered bytes checked in order against an expected-byte queue.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int DIV  = 10;
  localparam int HALF = 5;
  localparam int LAT  = 2 + HALF + 9 * DIV + 1;
  localparam int FRM  = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLK_FREQ(1), .BAUD(100000)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) tick();
    end
    rx = stop;
    repeat (DIV) tick();
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (data_valid === 1'b1 && data_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL hs_unexpected got %h exp none", data_out);
      end else begin
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL hs_data got %h exp %h", data_out, e);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; rx = 1'b1; data_ready = 1'b0;
    repeat (3) tick();
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", data_out); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", data_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b exp 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", overrun); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, IDLE); end
    rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    logic ferr_seen = 1'b0;
    data_ready = 1'b1;
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int k = 1; k <= LAT + 1; k++) begin
          tick();
          if (frame_err === 1'b1) ferr_seen = 1'b1;
          if (k == LAT - 1) begin
            checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %b exp 0", data_valid); end
          end
          if (k == LAT) begin
            checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", data_valid); end
            checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", data_out); end
          end
          if (k == LAT + 1) begin
            checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b exp 0", data_valid); end
          end
        end
      end
    join
    checks++; if (ferr_seen !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b exp 0", ferr_seen); end
  endtask

  task automatic test_glitch();
    logic bad = 1'b0;
    data_ready = 1'b1;
    rx = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) rx = 1'b1;
      if (data_valid === 1'b1 || frame_err === 1'b1) bad = 1'b1;
      if (k == 7) begin
        checks++; if (dbg_state !== START) begin errors++; $display("FAIL glitch_start got %0d exp %0d", dbg_state, START); end
      end
      if (k == 8) begin
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL glitch_idle got %0d exp %0d", dbg_state, IDLE); end
      end
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL glitch_outputs got %b exp 0", bad); end
  endtask

  task automatic test_frame_err();
    int   pulses = 0;
    logic vseen = 1'b0;
    logic wbad = 1'b0;
    data_ready = 1'b1;
    fork
      begin
        send_frame(8'h55, 1'b0);
        repeat (30) tick();
        rx = 1'b1;
        repeat (5) tick();
      end
      begin
        for (int k = 1; k <= FRM + 35; k++) begin
          tick();
          if (frame_err === 1'b1) pulses++;
          if (data_valid === 1'b1) vseen = 1'b1;
          if (k == LAT) begin
            checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_pulse got %b exp 1", frame_err); end
          end
          if (k > LAT && k <= FRM + 32 && dbg_state !== WAIT_IDLE) wbad = 1'b1;
          if (k == FRM + 33) begin
            checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL ferr_idle got %0d exp %0d", dbg_state, IDLE); end
          end
        end
      end
    join
    checks++; if (pulses != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", pulses); end
    checks++; if (vseen !== 1'b0) begin errors++; $display("FAIL ferr_valid got %b exp 0", vseen); end
    checks++; if (wbad !== 1'b0) begin errors++; $display("FAIL ferr_wait got %b exp 0", wbad); end
  endtask

  task automatic test_overrun();
    data_ready = 1'b0;
    exp_q.push_back(8'h3C);
    fork
      begin
        send_frame(8'h3C, 1'b1);
        send_frame(8'h81, 1'b1);
      end
      begin
        for (int k = 1; k <= 2 * FRM; k++) begin
          tick();
          if (k == LAT) begin
            checks++; if (data_valid !== 1'b1 || data_out !== 8'h3C) begin errors++; $display("FAIL ovr_first got %b/%h exp 1/3c", data_valid, data_out); end
          end
          if (k == FRM + LAT - 1) begin
            checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun); end
          end
          if (k == FRM + LAT) begin
            checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
            checks++; if (data_out !== 8'h3C || data_valid !== 1'b1) begin errors++; $display("FAIL ovr_hold got %b/%h exp 1/3c", data_valid, data_out); end
          end
        end
      end
    join
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_clear got %b exp 0", data_valid); end
  endtask

  task automatic test_same_cycle();
    logic [7:0] x, y;
    x = 8'($urandom_range(0, 255));
    y = ~x;
    data_ready = 1'b0;
    exp_q.push_back(x);
    exp_q.push_back(y);
    send_frame(x, 1'b1);
    fork
      send_frame(y, 1'b1);
      begin
        for (int k = 1; k <= LAT; k++) begin
          tick();
          if (k == LAT - 1) begin
            checks++; if (data_valid !== 1'b1 || data_out !== x) begin errors++; $display("FAIL same_held got %b/%h exp 1/%h", data_valid, data_out, x); end
            data_ready = 1'b1;
          end
          if (k == LAT) begin
            data_ready = 1'b0;
            checks++; if (data_valid !== 1'b1 || data_out !== y) begin errors++; $display("FAIL same_load got %b/%h exp 1/%h", data_valid, data_out, y); end
            checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL same_ovr got %b exp 0", overrun); end
          end
        end
      end
    join
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL same_drain got %b exp 0", data_valid); end
  endtask

  task automatic test_reset_mid();
    logic vseen = 1'b0;
    data_ready = 1'b1;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (55) tick();
        rst = 1'b0;
        tick();
        checks++; if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++; $display("FAIL midrst_outputs got %h/%b/%b/%b exp 00/0/0/0", data_out, data_valid, frame_err, overrun);
        end
        checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL midrst_state got %0d exp %0d", dbg_state, IDLE); end
        tick();
        rst = 1'b1;
        for (int k = 58; k <= FRM; k++) begin
          tick();
          if (data_valid === 1'b1) vseen = 1'b1;
        end
      end
    join
    checks++; if (vseen !== 1'b0) begin errors++; $display("FAIL midrst_ghost got %b exp 0", vseen); end
    exp_q.push_back(8'h0F);
    fork
      send_frame(8'h0F, 1'b1);
      begin
        for (int k = 1; k <= LAT; k++) begin
          tick();
          if (k == LAT) begin
            checks++; if (data_valid !== 1'b1 || data_out !== 8'h0F) begin errors++; $display("FAIL midrst_next got %b/%h exp 1/0f", data_valid, data_out); end
          end
        end
      end
    join
  endtask

  task automatic test_random();
    logic [7:0] b;
    int gap;
    data_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      b   = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 12);
      repeat (gap) tick();
      exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    repeat (5) tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain got %0d exp 0", exp_q.size()); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
